// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding
// and the requester-pointer width.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int NREQ_DEF = 4;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W = ptr_w(NREQ_DEF);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and serializer bundle between the arbiter (slave side)
// and its environment (master side).
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    grant;
    logic [DW-1:0]      tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic               tx_done;
    logic               timeout;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, grant, tx_data, tx_start, timeout
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, grant, tx_data, tx_start, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after
// ptr_i, wrapping modulo N; returns one-hot grant and its index.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = PW'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter in front of the UART transmitter.
// Define UART_ARB_TIMEOUT_EN to revoke grants from stalled owners.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               RST,
    uart_tx_arbiter_if.slave   bus
);

    localparam int PW = ptr_w(NREQ);

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            last_q, last_d;
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]     cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            ld_open;
    logic            hs;
    logic [PW-1:0]   nxt_ptr;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign ld_open = (state_q == LOAD) && !bus.tx_busy;
    assign hs      = ld_open && bus.req_valid[gidx_q];
    assign nxt_ptr = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

    assign bus.req_ready = grant_q & {NREQ{ld_open}};
    assign bus.grant     = grant_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        last_d     = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = LOAD;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
                    tx_data_d  = bus.req_data[gidx_q*DW +: DW];
                    tx_start_d = 1'b1;
                    last_d     = bus.req_last[gidx_q];
                    state_d    = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d      = '0;
                end else if (!bus.req_valid[gidx_q]) begin
                    // owner went quiet: count idle cycles toward revocation
                    if (cnt_q == 16'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                        ptr_d     = nxt_ptr;
                        grant_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end
            end
            WAIT: begin
                if (bus.tx_done) begin
                    if (last_q) begin
                        state_d = IDLE;
                        ptr_d   = nxt_ptr;
                        grant_d = '0;
                    end else begin
                        state_d = LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            last_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            last_q     <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a serializer
// model and an expected-byte queue checked on every tx_start.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 50000;
`endif

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic RST = 1'b0;
    logic force_busy = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   ser_cnt = 0;
    logic [3:0] hs_q = '0;

    byte_t rq[4][$];
    exp_t  sb[$];

    uart_tx_arbiter_if #(.NREQ(4), .DW(8)) bus ();

    uart_tx_arbiter #(.NREQ(4), .DW(8), .TIMEOUT(TO)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // requester agents, serializer model and output monitor
    initial begin
        exp_t       e;
        logic [3:0] eg;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (hs_q[i] && rq[i].size() > 0)
                    void'(rq[i].pop_front());
            bus.tx_done = 1'b0;
            if (!RST) begin
                ser_cnt = 0;
            end else if (bus.tx_start) begin
                ser_cnt = 10;
            end else if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) bus.tx_done = 1'b1;
            end
            bus.tx_busy = (ser_cnt > 0) || force_busy;
            if (RST && bus.tx_start) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: tx_data=%h grant=%b, required no start",
                             bus.tx_data, bus.grant);
                end else begin
                    e  = sb.pop_front();
                    eg = 4'(1 << e.idx);
                    if (bus.tx_data !== e.data || bus.grant !== eg) begin
                        failures++;
                        $display("FAIL sb_byte: tx_data=%h grant=%b, required %h %b",
                                 bus.tx_data, bus.grant, e.data, eg);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                bus.req_valid[i] = rq[i].size() > 0;
                if (rq[i].size() > 0) begin
                    bus.req_data[i*8 +: 8] = rq[i][0].data;
                    bus.req_last[i]        = rq[i][0].last;
                end else begin
                    bus.req_data[i*8 +: 8] = 8'h00;
                    bus.req_last[i]        = 1'b0;
                end
            end
            #1;
            hs_q = RST ? (bus.req_valid & bus.req_ready) : 4'b0;
        end
    end

    task automatic clear_all();
        for (int i = 0; i < 4; i++) rq[i].delete();
        sb.delete();
        force_busy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        RST = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()
                + sb.size() > 0 || bus.grant !== 4'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #2;
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL %s_drain: %0d bytes pending, grant=%b, required drained",
                     name, sb.size(), bus.grant);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        RST = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 4'b0 || bus.req_ready !== 4'b0) begin
            failures++;
            $display("FAIL reset_grant: grant=%b ready=%b, required 0 0",
                     bus.grant, bus.req_ready);
        end
        checks++;
        if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_tx: start=%b data=%h timeout=%b, required 0 00 0",
                     bus.tx_start, bus.tx_data, bus.timeout);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        rq[1].push_back('{1'b0, 8'h41});
        rq[1].push_back('{1'b1, 8'h42});
        sb.push_back('{1, 8'h41});
        sb.push_back('{1, 8'h42});
        wait_drain("single");
        checks++;
        if (dut.ptr_q !== 2'd2) begin
            failures++;
            $display("FAIL single_ptr: ptr=%0d, required 2", dut.ptr_q);
        end
    endtask

    task automatic test_contention();
        do_reset();
        rq[0].push_back('{1'b0, 8'hA0});
        rq[0].push_back('{1'b1, 8'hA1});
        rq[2].push_back('{1'b0, 8'hC0});
        rq[2].push_back('{1'b1, 8'hC1});
        sb.push_back('{0, 8'hA0});
        sb.push_back('{0, 8'hA1});
        sb.push_back('{2, 8'hC0});
        sb.push_back('{2, 8'hC1});
        wait_drain("contention");
        checks++;
        if (dut.ptr_q !== 2'd3) begin
            failures++;
            $display("FAIL contention_ptr: ptr=%0d, required 3", dut.ptr_q);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                rq[i].push_back('{1'b1, 8'(16 * i + k)});
                sb.push_back('{i, 8'(16 * i + k)});
            end
        wait_drain("fairness");
        checks++;
        if (dut.ptr_q !== 2'd0) begin
            failures++;
            $display("FAIL fairness_ptr: ptr=%0d, required 0", dut.ptr_q);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        force_busy = 1'b1;
        rq[0].push_back('{1'b1, 8'h5A});
        sb.push_back('{0, 8'h5A});
        repeat (6) begin
            @(negedge clk);
            #2;
            checks++;
            if (bus.req_ready !== 4'b0 || bus.tx_start !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: ready=%b start=%b, required 0000 0",
                         bus.req_ready, bus.tx_start);
            end
        end
        force_busy = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_ready: ready=%b, required 0001", bus.req_ready);
        end
        @(negedge clk);
        #2;
        checks++;
        if (bus.tx_start !== 1'b1) begin
            failures++;
            $display("FAIL bp_start: start=%b, required 1", bus.tx_start);
        end
        wait_drain("bp");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        rq[1].push_back('{1'b0, 8'h11});
        rq[1].push_back('{1'b0, 8'h12});
        rq[1].push_back('{1'b1, 8'h13});
        sb.push_back('{1, 8'h11});
        while (bus.tx_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL rmid_start: start=%b, required 1", bus.tx_start);
        end
        repeat (3) @(negedge clk);
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 4'b0 || bus.req_ready !== 4'b0 || bus.tx_start !== 1'b0
            || bus.tx_data !== 8'h00) begin
            failures++;
            $display("FAIL rmid_outs: grant=%b ready=%b start=%b data=%h, required 0",
                     bus.grant, bus.req_ready, bus.tx_start, bus.tx_data);
        end
        clear_all();
        @(negedge clk);
        RST = 1'b1;
        rq[1].push_back('{1'b1, 8'h55});
        rq[3].push_back('{1'b1, 8'h77});
        sb.push_back('{1, 8'h55});
        sb.push_back('{3, 8'h77});
        wait_drain("rmid");
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        do_reset();
        rq[3].push_back('{1'b0, 8'h33});
        sb.push_back('{3, 8'h33});
        while (bus.tx_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        rq[0].push_back('{1'b1, 8'h0F});
        sb.push_back('{0, 8'h0F});
        n = 0;
        while (bus.timeout !== 1'b1 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 100 || bus.grant !== 4'b0) begin
            failures++;
            $display("FAIL to_pulse: timeout=%b grant=%b, required 1 0000",
                     bus.timeout, bus.grant);
        end
        @(negedge clk);
        #2;
        checks++;
        if (bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_width: timeout=%b, required 0", bus.timeout);
        end
        wait_drain("to");
        checks++;
        if (dut.ptr_q !== 2'd1) begin
            failures++;
            $display("FAIL to_ptr: ptr=%0d, required 1", dut.ptr_q);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
